rx_core: RTL
============

# rx_core

Receive-side UART core, the downstream counterpart of the transmit core: it recovers frames from the serial line driven by a peer transmitter and presents each received byte to the host. It accepts a 16x oversampling strobe from the baud-rate module and supports the same frame options as the transmit side: data-bit order, parity enable and parity method. Each byte goes into a one-entry holding register with a valid/ack handshake. Parity, framing and overrun errors are reported as sticky flags.

## Interface
- OVERSAMPLE, 16: oversample ticks per bit; legal values 8..32.
- SYNC_STAGES, 2: synchronizer flops on Rx_i; minimum 2.
- clk  input  1  system clock, >= 40 MHz.
- rst  input  1  asynchronous active-low reset, released synchronously to clk.
- p_OverSample_i  input  1  one-clk strobe at OVERSAMPLE x baud rate.
- Rx_i  input  1  asynchronous serial line; idle level is high.
- p_ParityEnable_i  input  1  1 = parity bit present.
- p_BigEnd_i  input  1  1 = MSB first; 0 = LSB first.
- ParityMethod_i  input  1  0 = even, 1 = odd.
- p_ack_i  input  1  host has taken data_o.
- p_ErrClear_i  input  1  one-clk pulse that clears all sticky error flags.
- data_o  output  8  received byte.
- p_valid_o  output  1  data_o holds an unread byte.
- p_ParityErr_o  output  1  sticky parity error.
- p_FrameErr_o  output  1  sticky framing error (stop bit sampled low).
- p_OverrunErr_o  output  1  sticky overrun error.

## Operation
- Rx_i passes through SYNC_STAGES flops, each reset to 1, so no false start is seen after reset.
- The sample counter (0..OVERSAMPLE-1) advances only on p_OverSample_i.
- Bit value is the majority vote of samples at counts M-1, M and M+1, with M = OVERSAMPLE/2. The decision is made at count M+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronized 1->0 transition; the counter is cleared.
  - START: at decision, vote 1 -> IDLE (glitch rejected). Vote 0 -> latch p_BigEnd_i, p_ParityEnable_i and ParityMethod_i for the whole frame, clear the bit counter, and go to DATA at count OVERSAMPLE-1.
  - DATA: 8 bits. LSB-first shifts right, inserting at bit 7. MSB-first shifts left, inserting at bit 0. A running XOR tracks data parity. After bit 7, go to PARITY if parity is enabled, else STOP.
  - PARITY: compare the received bit with the expected value. Expected = XOR(data) for even, ~XOR(data) for odd. A mismatch sets the parity-error flag for this frame.
  - STOP: at decision, vote 0 sets p_FrameErr_o. The byte is delivered and the FSM returns to IDLE immediately at the decision point, not at the end of the bit. This allows back-to-back frames and half-bit clock tolerance.
- Delivery:
  - If p_valid_o = 0: data_o <= byte, p_valid_o <= 1, and parity/frame flags are OR-ed into the sticky flags.
  - If p_valid_o = 1: the new byte is dropped, data_o is unchanged, p_OverrunErr_o <= 1, and the dropped byte's parity/frame flags are discarded.
- p_ack_i while p_valid_o = 1 clears p_valid_o. p_ack_i while p_valid_o = 0 is ignored.
- p_ack_i in the same clk as a delivery: the ack clears the old byte, the new byte loads, p_valid_o stays 1, and no overrun is flagged.
- p_ErrClear_i in the same clk as an error event: the set wins.
- Config inputs changing mid-frame have no effect until the next start.

## Timing
- Reset values: data_o = 0x00, p_valid_o = 0, all error flags 0, FSM in IDLE.
- Reset mid-frame aborts the frame. Nothing is delivered.
- Start detection latency is SYNC_STAGES + 1 clk after the Rx_i edge.
- p_valid_o rises 1 clk after the clk carrying the STOP decision strobe.
- p_valid_o falls 1 clk after p_ack_i is sampled.
- Error flags update in the same clk as p_valid_o and clear 1 clk after p_ErrClear_i.
- A full frame (start + 8 data + optional parity + 1 stop) completes in (1 + 8 + P) x OVERSAMPLE + M + 2 ticks from the start edge, where P = 1 with parity enabled and 0 without.

## Structure
- Shared package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - constants DATA_BITS = 8 and the default OVERSAMPLE;
  - the vote-index function of OVERSAMPLE.
- Sub-module rx_bit_sampler contains the synchronizer, falling-edge detect, sample counter and 3-sample majority vote. It outputs p_StartEdge, p_BitDecide, p_BitEnd and BitValue.
- rx_core holds the FSM, shift register, parity check, holding register and error flags.

## Test plan
- 0xA5, LSB-first, no parity, OVERSAMPLE = 16 -> data_o = 0xA5, p_valid_o = 1, all flags 0; p_ack_i -> p_valid_o = 0 next clk.
- 0x3C, MSB-first, odd parity, correct parity bit 1 -> data_o = 0x3C, p_ParityErr_o = 0. Resend with parity bit 0 -> p_ParityErr_o = 1; p_ErrClear_i -> 0.
- 0x55 with the stop bit forced low -> data_o = 0x55, p_FrameErr_o = 1.
- Low glitch of 4 ticks on an idle line -> FSM returns to IDLE, p_valid_o stays 0. Then a valid frame 0x81 -> data_o = 0x81.
- Two back-to-back frames 0x11 and 0x22 with no ack -> data_o = 0x11, p_OverrunErr_o = 1. Same frames with an ack in the delivery clk of 0x22 -> data_o = 0x22, p_OverrunErr_o = 0.
- Assert rst at bit 4 of frame 0xF0 -> all outputs return to reset values. The next frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// oversample index at which the middle bit sample is taken.
package uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Centre sample of a bit; the majority vote uses this index and its two neighbours.
    function automatic int unsigned vote_idx(input int unsigned oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Serial line front end: synchronizer, falling-edge detect, oversample
// counter and 3-sample majority vote around the bit centre.
module rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic p_OverSample_i,
    input  logic Rx_i,
    input  logic p_CntClear_i,
    output logic p_StartEdge_o,
    output logic p_BitDecide_o,
    output logic p_BitEnd_o,
    output logic BitValue_o
);

    localparam int unsigned M  = vote_idx(OVERSAMPLE);
    localparam int unsigned CW = $clog2(OVERSAMPLE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchronizer and edge history reset high so release never fakes a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            smp_q     <= '1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], Rx_i};
            rx_prev_q <= rx_s;
            cnt_q     <= cnt_d;
            smp_q     <= smp_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        smp_d = smp_q;
        if (p_CntClear_i) begin
            cnt_d = '0;
        end else if (p_OverSample_i) begin
            cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CW'(M - 1)) smp_d[0] = rx_s;
            if (cnt_q == CW'(M))     smp_d[1] = rx_s;
        end
    end

    assign p_StartEdge_o = rx_prev_q & ~rx_s;
    assign p_BitDecide_o = p_OverSample_i & ~p_CntClear_i & (cnt_q == CW'(M + 1));
    assign p_BitEnd_o    = p_OverSample_i & ~p_CntClear_i & (cnt_q == CW'(OVERSAMPLE - 1));
    assign BitValue_o    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

endmodule

// File: rtl/rx_core.sv
// UART receiver: frame FSM, data shift register, parity check, one-entry
// holding register with valid/ack handshake and sticky error flags.
module rx_core
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_OverSample_i,
    input  logic       Rx_i,
    input  logic       p_ParityEnable_i,
    input  logic       p_BigEnd_i,
    input  logic       ParityMethod_i,
    input  logic       p_ack_i,
    input  logic       p_ErrClear_i,
    output logic [7:0] data_o,
    output logic       p_valid_o,
    output logic       p_ParityErr_o,
    output logic       p_FrameErr_o,
    output logic       p_OverrunErr_o
);

    rx_state_e   state_q, state_d;
    logic        start_edge, bit_decide, bit_end, bit_val, cnt_clr;
    logic        start_ok, shift_en, par_check, deliver;

    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic        par_acc_q, par_acc_d;
    logic        frm_perr_q, frm_perr_d;
    logic        big_end_q, big_end_d, par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

    assign cnt_clr = (state_q == StIdle) & start_edge;

    rx_bit_sampler #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk            (clk),
        .rst            (rst),
        .p_OverSample_i (p_OverSample_i),
        .Rx_i           (Rx_i),
        .p_CntClear_i   (cnt_clr),
        .p_StartEdge_o  (start_edge),
        .p_BitDecide_o  (bit_decide),
        .p_BitEnd_o     (bit_end),
        .BitValue_o     (bit_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_edge) state_d = StStart;
            StStart: begin
                if (bit_decide && bit_val) state_d = StIdle;
                else if (bit_end)          state_d = StData;
            end
            StData: begin
                if (bit_end && bitcnt_q == 4'(DATA_BITS)) state_d = par_en_q ? StParity : StStop;
            end
            StParity: if (bit_end)    state_d = StStop;
            StStop:   if (bit_decide) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        start_ok  = (state_q == StStart)  & bit_decide & ~bit_val;
        shift_en  = (state_q == StData)   & bit_decide;
        par_check = (state_q == StParity) & bit_decide;
        deliver   = (state_q == StStop)   & bit_decide;
    end

    always_comb begin
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        par_acc_d  = par_acc_q;
        frm_perr_d = frm_perr_q;
        big_end_d  = big_end_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = p_ErrClear_i ? 1'b0 : perr_q;
        ferr_d     = p_ErrClear_i ? 1'b0 : ferr_q;
        ovr_d      = p_ErrClear_i ? 1'b0 : ovr_q;

        if (start_ok) begin
            big_end_d  = p_BigEnd_i;
            par_en_d   = p_ParityEnable_i;
            par_odd_d  = ParityMethod_i;
            bitcnt_d   = '0;
            par_acc_d  = 1'b0;
            frm_perr_d = 1'b0;
        end
        if (shift_en) begin
            shift_d   = big_end_q ? {shift_q[6:0], bit_val} : {bit_val, shift_q[7:1]};
            par_acc_d = par_acc_q ^ bit_val;
            bitcnt_d  = bitcnt_q + 4'd1;
        end
        if (par_check) frm_perr_d = bit_val ^ (par_acc_q ^ par_odd_q);

        if (p_ack_i && valid_q) valid_d = 1'b0;
        // An ack in the delivery clk frees the slot, so the new byte is not an overrun.
        if (deliver) begin
            if (!valid_q || p_ack_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = perr_d | frm_perr_q;
                ferr_d  = ferr_d | ~bit_val;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            bitcnt_q   <= '0;
            par_acc_q  <= 1'b0;
            frm_perr_q <= 1'b0;
            big_end_q  <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            par_acc_q  <= par_acc_d;
            frm_perr_q <= frm_perr_d;
            big_end_q  <= big_end_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_o         = data_q;
    assign p_valid_o      = valid_q;
    assign p_ParityErr_o  = perr_q;
    assign p_FrameErr_o   = ferr_q;
    assign p_OverrunErr_o = ovr_q;

endmodule
